dsp_i2s_transmitter: RTL
========================

// Module: dsp_i2s_transmitter
// PURPOSE
//  Downstream consumer of the DSP mixer output. Accepts 16-bit mono samples on audio_output/audio_valid,
//  buffers them in a small FIFO and serializes each sample as a standard I2S stereo frame for an
//  external DAC, duplicating the sample to left and right. Frame timing comes from an internal divider.
//  The DSP has no backpressure, so the block absorbs rate mismatch and reports overflow and underrun.
// PARAMETERS
//  SAMPLE_WIDTH  16  bits per channel slot; frame = 2*SAMPLE_WIDTH bclk periods
//  FIFO_DEPTH    4   sample FIFO entries; must be a power of two, >= 2
//  BCLK_DIV      8   clock cycles per bclk half-period; bclk period = 2*BCLK_DIV clocks; >= 1
// PORTS
//  clock         in   1    system clock; all logic is clocked on the rising edge
//  reset         in   1    asynchronous reset, active-low (0 = in reset)
//  enable        in   1    1 = bclk divider runs; 0 = serializer freezes, FIFO still accepts samples
//  audio_output  in   16   sample from the DSP, two's complement
//  audio_valid   in   1    one-cycle push strobe for audio_output
//  clear_flags   in   1    clears overflow and underrun
//  i2s_bclk      out  1    I2S bit clock
//  i2s_lrclk     out  1    I2S word select; 0 = left, 1 = right
//  i2s_sdata     out  1    I2S serial data, MSB first
//  fifo_level    out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  overflow      out  1    sticky: a push was dropped
//  underrun      out  1    sticky: a frame started with the FIFO empty
// BEHAVIOUR
//  Reset (reset=0, async): bclk=0, lrclk=0, sdata=0, divider=0, bit_index=0, FIFO empty, level=0,
//   flags=0, held sample=0. Outputs are registered. Release is synchronous to clock.
//  Divider: while enable=1, count 0..BCLK_DIV-1. At terminal count, toggle bclk and clear the count.
//   While enable=0, count, bclk, lrclk, sdata and bit_index all hold. FIFO push and flags stay live.
//  Falling bclk event (the cycle bclk is driven 1->0): bit_index <= (bit_index+1) mod 32.
//   With k = new bit_index: lrclk <= (k >= 16).
//   sdata <= bit (31 - ((k-1) mod 32)) of frame word {S,S}.
//   Result: lrclk leads the MSB by one bclk, as standard I2S requires.
//  Frame load: on the falling event where k becomes 1:
//   - if FIFO non-empty: pop, S <= head; that same edge drives sdata = new S[15].
//   - if FIFO empty: S unchanged (last sample repeats); underrun <= 1.
//  Receiver samples sdata and lrclk on the rising bclk; rising events change no state except bclk.
//  FIFO push: audio_valid=1 with not full: write at wr_ptr. Full with no pop in the same cycle:
//   sample dropped, overflow <= 1, contents unchanged.
//  Push and pop in the same cycle:
//   - when full: both take effect, level unchanged, no overflow.
//   - when empty: the pop sees empty (underrun); the push lands and level becomes 1.
//  Pointers: log2(FIFO_DEPTH) bits, wrap naturally. level = wr_cnt - rd_cnt, using an extra MSB.
//  Flags: clear_flags=1 zeroes both flags. A set event in the same cycle wins; the flag reads 1 next cycle.
//  Latency: a sample pushed into an empty FIFO leaves on the next k=1 event. Worst case is one frame
//   (64*BCLK_DIV clocks) plus the push cycle.
// STRUCTURE
//  dsp_audio_pkg: SAMPLE_WIDTH default, FRAME_BITS=32, localparam for the k=1 load index.
//  Sub-module audio_sample_fifo: synchronous FIFO with push/pop/full/empty/level, parameterized
//   by width and depth. Reused later for the SPC700 port buffers.
//  Top level: divider, bit_index counter, frame register S, output registers, flag logic.
// TESTING  (BCLK_DIV=2 => bclk period 4 clocks, frame 128 clocks)
//  1. Reset mid-frame: assert reset=0 at bit_index 20 -> next cycle all outputs 0, fifo_level=0.
//     Flags are 0 after release.
//  2. Push 16'hA5C3, enable=1: capture 32 sdata bits on rising bclk from lrclk 1->0.
//     -> left slot = A5C3 starting one bclk after lrclk falls; right slot = A5C3; lrclk 16 low/16 high.
//  3. Push 5 samples back-to-back, serializer disabled -> fifo_level=4, overflow=1.
//     The first 4 samples are emitted in order.
//  4. No pushes after one sample 16'h8001 -> every later frame repeats 8001 and underrun=1.
//     clear_flags then reads 0 until the next empty k=1 event.
//  5. FIFO full and audio_valid on the exact k=1 pop cycle -> level stays 4, overflow stays 0.
//  6. enable=0 for 37 clocks mid-frame -> bclk/lrclk/sdata frozen.
//     The resumed bit sequence is identical to an uninterrupted reference.

Source files
------------

// File: rtl/dsp_audio_pkg.sv
// Shared constants and types for the DSP audio output path.
// Used by the I2S transmitter and the sample FIFO.
package dsp_audio_pkg;

   localparam int DEFAULT_SAMPLE_WIDTH = 16;
   localparam int FRAME_BITS           = 2 * DEFAULT_SAMPLE_WIDTH;
   // Bit index at which a new frame word is taken from the FIFO.
   localparam int LOAD_INDEX           = 1;

   typedef enum logic [1:0] {
      EV_NONE,
      EV_RISE,
      EV_FALL
   } bclk_evt_e;

endpackage

// File: rtl/audio_sample_fifo.sv
// Small synchronous FIFO with a combinational head, level count and push/pop guards.
// A pop on empty is ignored; a push on full only lands when a pop frees a slot in the same cycle.
module audio_sample_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_cnt_q, wr_cnt_d;
   logic [AW:0]      rd_cnt_q, rd_cnt_d;
   logic             do_push, do_pop;

   assign level_o  = wr_cnt_q - rd_cnt_q;
   assign empty_o  = (level_o == '0);
   assign full_o   = (level_o == (AW+1)'(DEPTH));
   assign do_pop   = pop_i & ~empty_o;
   assign do_push  = push_i & (~full_o | do_pop);
   assign head_o   = mem_q[rd_cnt_q[AW-1:0]];
   assign wr_cnt_d = do_push ? wr_cnt_q + 1'b1 : wr_cnt_q;
   assign rd_cnt_d = do_pop  ? rd_cnt_q + 1'b1 : rd_cnt_q;

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_cnt_q[AW-1:0]] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

endmodule

// File: rtl/dsp_i2s_transmitter.sv
// Buffers mono DSP samples and serializes each one as an I2S stereo frame (same sample left and right).
// Bit clock comes from an internal divider; overflow and underrun are sticky until cleared.
module dsp_i2s_transmitter
   import dsp_audio_pkg::*;
#(
   parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
   parameter int FIFO_DEPTH   = 4,
   parameter int BCLK_DIV     = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        enable_i,
   input  logic [SAMPLE_WIDTH-1:0]     audio_output_i,
   input  logic                        audio_valid_i,
   input  logic                        clear_flags_i,
   output logic                        i2s_bclk_o,
   output logic                        i2s_lrclk_o,
   output logic                        i2s_sdata_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
   output logic                        overflow_o,
   output logic                        underrun_o
);

   localparam int FRAME_W = 2 * SAMPLE_WIDTH;
   localparam int IDX_W   = $clog2(FRAME_W);
   localparam int SLOT_W  = $clog2(SAMPLE_WIDTH);
   localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

   logic [DIV_W-1:0]        div_q, div_d;
   logic                    bclk_q, bclk_d;
   logic                    lrclk_q, lrclk_d;
   logic                    sdata_q, sdata_d;
   logic [IDX_W-1:0]        idx_q, idx_d, k_next;
   logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
   logic                    ovf_q, ovf_d, und_q, und_d;
   logic [SAMPLE_WIDTH-1:0] fifo_head, cur_sample;
   logic                    fifo_full, fifo_empty, fifo_pop;
   logic                    terminal, load_evt;
   logic [SLOT_W-1:0]       slot_sel;
   bclk_evt_e               evt;

   audio_sample_fifo #(
      .WIDTH (SAMPLE_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (audio_valid_i),
      .data_i  (audio_output_i),
      .pop_i   (fifo_pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level_o)
   );

   assign terminal = enable_i && (div_q == DIV_W'(BCLK_DIV - 1));
   assign k_next   = idx_q + 1'b1;

   always_comb begin
      evt = EV_NONE;
      if (terminal) evt = bclk_q ? EV_FALL : EV_RISE;
   end

   assign load_evt   = (evt == EV_FALL) && (k_next == IDX_W'(LOAD_INDEX));
   assign fifo_pop   = load_evt & ~fifo_empty;
   assign cur_sample = fifo_pop ? fifo_head : sample_q;
   // The bit sent for new index k is slot position (k-1) mod SAMPLE_WIDTH, i.e. the old index.
   assign slot_sel   = ~idx_q[SLOT_W-1:0];

   always_comb begin
      div_d    = div_q;
      bclk_d   = bclk_q;
      idx_d    = idx_q;
      lrclk_d  = lrclk_q;
      sdata_d  = sdata_q;
      sample_d = sample_q;
      if (enable_i) div_d = terminal ? '0 : div_q + 1'b1;
      if (evt != EV_NONE) bclk_d = ~bclk_q;
      if (evt == EV_FALL) begin
         idx_d    = k_next;
         lrclk_d  = (k_next >= IDX_W'(SAMPLE_WIDTH));
         sdata_d  = cur_sample[slot_sel];
         sample_d = cur_sample;
      end
   end

   // A set event in the same cycle as clear_flags wins.
   assign ovf_d = (audio_valid_i & fifo_full & ~fifo_pop) | (ovf_q & ~clear_flags_i);
   assign und_d = (load_evt & fifo_empty) | (und_q & ~clear_flags_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q    <= '0;
         bclk_q   <= 1'b0;
         idx_q    <= '0;
         lrclk_q  <= 1'b0;
         sdata_q  <= 1'b0;
         sample_q <= '0;
         ovf_q    <= 1'b0;
         und_q    <= 1'b0;
      end else begin
         div_q    <= div_d;
         bclk_q   <= bclk_d;
         idx_q    <= idx_d;
         lrclk_q  <= lrclk_d;
         sdata_q  <= sdata_d;
         sample_q <= sample_d;
         ovf_q    <= ovf_d;
         und_q    <= und_d;
      end
   end

   assign i2s_bclk_o  = bclk_q;
   assign i2s_lrclk_o = lrclk_q;
   assign i2s_sdata_o = sdata_q;
   assign overflow_o  = ovf_q;
   assign underrun_o  = und_q;

endmodule
